cb_read_sched: RTL and testbench

//  Shares the single covariance-buffer (CB) port-A read between three operand requesters (A, B, M).

---
 rtl/cb_read_sched_if.sv | 39 +++
 rtl/cb_read_sched.sv | 172 +++++++++++++++++
 tb/tb_cb_read_sched.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cb_read_sched_if.sv
// cb_read_sched_if: request/grant handshake, CB port-A read bus and
// per-requester valid/done flags of the covariance-buffer read scheduler.
// slave  = scheduler side, master = requester/BRAM side.
interface cb_read_sched_if #(
  parameter int CB_AW = 10,
  parameter int CNT_W = 8
);
  logic [2:0]       req;
  logic [CB_AW-1:0] req_addr_a;
  logic [CB_AW-1:0] req_addr_b;
  logic [CB_AW-1:0] req_addr_m;
  logic [CNT_W-1:0] req_len_a;
  logic [CNT_W-1:0] req_len_b;
  logic [CNT_W-1:0] req_len_m;
  logic [1:0]       req_dir_a;
  logic [1:0]       req_dir_b;
  logic [1:0]       req_dir_m;
  logic [2:0]       ack;
  logic             CB_ena;
  logic [CB_AW-1:0] CB_addra;
  logic [3:0]       CB_douta_sel;
  logic [2:0]       data_vld;
  logic [2:0]       done;
  logic             busy;

  modport slave (
    input  req, req_addr_a, req_addr_b, req_addr_m,
           req_len_a, req_len_b, req_len_m,
           req_dir_a, req_dir_b, req_dir_m,
    output ack, CB_ena, CB_addra, CB_douta_sel, data_vld, done, busy
  );

  modport master (
    output req, req_addr_a, req_addr_b, req_addr_m,
           req_len_a, req_len_b, req_len_m,
           req_dir_a, req_dir_b, req_dir_m,
    input  ack, CB_ena, CB_addra, CB_douta_sel, data_vld, done, busy
  );
endinterface

// File: rtl/cb_read_sched.sv
// cb_read_sched: arbitrates the single CB port-A read between requesters
// A/B/M, issues a burst of consecutive row reads for the winner and steers
// the mapper with a latency-aligned {target,dir} select.
// Optional feature macro CB_SCHED_RR_EN: round-robin arbitration (A->B->M);
// undefined gives fixed priority M > A > B.
module cb_read_sched #(
  parameter int CB_AW  = 10,
  parameter int CNT_W  = 8,
  parameter int RD_LAT = 1
) (
  input logic             clk,
  input logic             sys_rst,
  cb_read_sched_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t           state_q;
  logic [2:0]       ack_q;
  logic             ena_q;
  logic [CB_AW-1:0] addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       tgt_q;
  logic [1:0]       dir_q;
  logic             busy_q;
  logic             zl_q;
  logic [2:0]       vld_q;
  logic [2:0]       done_q;
`ifdef CB_SCHED_RR_EN
  logic [1:0]       ptr_q;
`endif

  // pipeline entry: [5] valid, [4] last row, [3:2] target, [1:0] dir
  logic [5:0] pipe_q [RD_LAT];
  logic [5:0] pipe_d;
  logic [5:0] pipe_out;

  logic [1:0]       win_idx;
  logic [2:0]       win_oh;
  logic [CB_AW-1:0] win_addr;
  logic [CNT_W-1:0] win_len;
  logic [1:0]       win_dir;

  function automatic logic [2:0] tgt_oh(input logic [1:0] t);
    case (t)
      2'd1:    tgt_oh = 3'b001;
      2'd2:    tgt_oh = 3'b010;
      2'd3:    tgt_oh = 3'b100;
      default: tgt_oh = 3'b000;
    endcase
  endfunction

  // arbitration: winner index 0=A, 1=B, 2=M and its command fields
  always_comb begin
    win_idx = 2'd0;
`ifdef CB_SCHED_RR_EN
    case (ptr_q)
      2'd1:    win_idx = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
      2'd2:    win_idx = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
      default: win_idx = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
    endcase
`else
    win_idx = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
`endif
    win_oh = 3'b001 << win_idx;
    case (win_idx)
      2'd1: begin
        win_addr = bus.req_addr_b; win_len = bus.req_len_b; win_dir = bus.req_dir_b;
      end
      2'd2: begin
        win_addr = bus.req_addr_m; win_len = bus.req_len_m; win_dir = bus.req_dir_m;
      end
      default: begin
        win_addr = bus.req_addr_a; win_len = bus.req_len_a; win_dir = bus.req_dir_a;
      end
    endcase
  end

  // read issued this cycle enters the pipe; idle slots carry zeros so the
  // pipe output doubles as the mapper select
  always_comb begin
    pipe_d   = ena_q ? {1'b1, (cnt_q == '0), tgt_q, dir_q} : '0;
    pipe_out = pipe_q[RD_LAT-1];
  end

  // RD_LAT-deep select/valid shift register
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= pipe_d;
      for (int unsigned i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // scheduler FSM with registered grant, read-port and flag outputs
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      ack_q   <= '0;
      ena_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      dir_q   <= '0;
      busy_q  <= 1'b0;
      zl_q    <= 1'b0;
      vld_q   <= '0;
      done_q  <= '0;
`ifdef CB_SCHED_RR_EN
      ptr_q   <= 2'd0;
`endif
    end else begin
      ack_q  <= '0;
      vld_q  <= pipe_out[5] ? tgt_oh(pipe_out[3:2]) : '0;
      done_q <= (pipe_out[5] && pipe_out[4]) ? tgt_oh(pipe_out[3:2]) : '0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (|bus.req) begin
            ack_q <= win_oh;
            tgt_q <= win_idx + 2'd1;
            dir_q <= win_dir;
`ifdef CB_SCHED_RR_EN
            ptr_q <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
`endif
            if (win_len == '0) begin
              zl_q    <= 1'b1;
              state_q <= S_DRAIN;
            end else begin
              ena_q   <= 1'b1;
              addr_q  <= win_addr;
              cnt_q   <= win_len - 1'b1;
              busy_q  <= 1'b1;
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (cnt_q == '0) begin
            ena_q   <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q - 1'b1;
          end
        end
        S_DRAIN: begin
          // leave when the last row reaches the pipe output, so IDLE
          // coincides with the final data_vld and the next grant is not delayed
          if (zl_q) begin
            zl_q    <= 1'b0;
            done_q  <= tgt_oh(tgt_q);
            state_q <= S_IDLE;
          end else if (pipe_out[5] && pipe_out[4]) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack          = ack_q;
  assign bus.CB_ena       = ena_q;
  assign bus.CB_addra     = addr_q;
  assign bus.CB_douta_sel = pipe_out[3:0];
  assign bus.data_vld     = vld_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_cb_read_sched.sv
// tb_cb_read_sched: directed then random requests; expected outputs are
// laid out per cycle in a schedule computed from the burst timing rules.
module tb_cb_read_sched;
  localparam int AW  = 10;
  localparam int CW  = 8;
  localparam int LAT = 2;
  localparam int NC  = 2000;

  logic clk = 1'b0;
  logic sys_rst;
  always #5 clk = ~clk;

  cb_read_sched_if #(.CB_AW(AW), .CNT_W(CW)) bus();

  cb_read_sched #(.CB_AW(AW), .CNT_W(CW), .RD_LAT(LAT)) dut (
    .clk(clk), .sys_rst(sys_rst), .bus(bus)
  );

  logic [2:0]    req_v;
  logic [AW-1:0] ra [3];
  logic [CW-1:0] rl [3];
  logic [1:0]    rd [3];

  assign bus.req        = req_v;
  assign bus.req_addr_a = ra[0];
  assign bus.req_addr_b = ra[1];
  assign bus.req_addr_m = ra[2];
  assign bus.req_len_a  = rl[0];
  assign bus.req_len_b  = rl[1];
  assign bus.req_len_m  = rl[2];
  assign bus.req_dir_a  = rd[0];
  assign bus.req_dir_b  = rd[1];
  assign bus.req_dir_m  = rd[2];

  // expected outputs per cycle (cycle n = interval after the n-th posedge)
  logic [2:0]    e_ack  [NC+64];
  logic          e_ena  [NC+64];
  logic [AW-1:0] e_addr [NC+64];
  logic [3:0]    e_sel  [NC+64];
  logic [2:0]    e_vld  [NC+64];
  logic [2:0]    e_done [NC+64];
  logic          e_busy [NC+64];

  int cyc, idle_from, rel_cyc, ptr;
  int total, bad;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    chk("ack",  16'(bus.ack),          16'(e_ack[cyc]));
    chk("ena",  16'(bus.CB_ena),       16'(e_ena[cyc]));
    chk("sel",  16'(bus.CB_douta_sel), 16'(e_sel[cyc]));
    chk("vld",  16'(bus.data_vld),     16'(e_vld[cyc]));
    chk("done", 16'(bus.done),         16'(e_done[cyc]));
    chk("busy", 16'(bus.busy),         16'(e_busy[cyc]));
    if (e_ena[cyc] || cyc == rel_cyc)
      chk("addr", 16'(bus.CB_addra), 16'(e_addr[cyc]));
  endtask

  task automatic clear_from(input int first);
    for (int i = first; i < NC + 64; i++) begin
      e_ack[i] = '0; e_ena[i] = 1'b0; e_addr[i] = '0; e_sel[i] = '0;
      e_vld[i] = '0; e_done[i] = '0; e_busy[i] = 1'b0;
    end
  endtask

  function automatic int pick(input logic [2:0] r);
`ifdef CB_SCHED_RR_EN
    for (int i = 0; i < 3; i++)
      if (r[(ptr + i) % 3]) return (ptr + i) % 3;
    return 0;
`else
    if (r[2]) return 2;
    if (r[0]) return 0;
    return 1;
`endif
  endfunction

  // schedule a burst granted to requester w with ack in cycle g
  task automatic grant(input int w, input int g);
    logic [2:0]    oh;
    logic [1:0]    t;
    logic [AW-1:0] a;
    int            n;
    oh = 3'b001 << w;
    t  = 2'(w + 1);
    n  = int'(rl[w]);
    e_ack[g] = oh;
`ifdef CB_SCHED_RR_EN
    ptr = (w + 1) % 3;
`endif
    if (n == 0) begin
      e_done[g+1] = oh;
      idle_from = g + 1;
    end else begin
      for (int k = 0; k < n; k++) begin
        a = ra[w] + AW'(k);
        e_ena[g+k]         = 1'b1;
        e_addr[g+k]        = a;
        e_sel[g+k+LAT]     = {t, rd[w]};
        e_vld[g+k+LAT+1]   = oh;
      end
      e_done[g+n+LAT] = oh;
      for (int k = 0; k <= n + LAT; k++) e_busy[g+k] = 1'b1;
      idle_from = g + n + LAT;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
    if (sys_rst && cyc == rel_cyc) begin
      sys_rst   = 1'b0;
      idle_from = cyc;
    end
    req_v = req_v & ~e_ack[cyc];
  endtask

  task automatic decide();
    if (!sys_rst && cyc >= idle_from && req_v != 3'b000)
      grant(pick(req_v), cyc + 1);
  endtask

  task automatic run(input int n);
    repeat (n) begin tick(); decide(); end
  endtask

  task automatic set_req(input int w, input logic [AW-1:0] a, input logic [CW-1:0] l,
                         input logic [1:0] d);
    ra[w] = a; rl[w] = l; rd[w] = d; req_v[w] = 1'b1;
  endtask

  task automatic do_reset();
    sys_rst   = 1'b1;
    rel_cyc   = cyc + 1;
    req_v     = '0;
    ptr       = 0;
    idle_from = 4 * NC;
    clear_from(cyc + 1);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; ptr = 0;
    idle_from = 4 * NC; rel_cyc = 3;
    sys_rst = 1'b1; req_v = '0;
    for (int w = 0; w < 3; w++) begin ra[w] = '0; rl[w] = '0; rd[w] = '0; end
    clear_from(0);

    run(3);
    // single burst
    tick(); set_req(0, 10'h010, 8'd4, 2'b01); decide(); run(10);
    // address wrap
    tick(); set_req(1, 10'h3FE, 8'd3, 2'b10); decide(); run(10);
    // contention, all held
    tick();
    set_req(0, 10'h100, 8'd2, 2'b11);
    set_req(1, 10'h200, 8'd2, 2'b01);
    set_req(2, 10'h300, 8'd2, 2'b10);
    decide(); run(30);
    // zero length
    tick(); set_req(2, 10'h050, 8'd0, 2'b01); decide(); run(5);
    // reset at the 2nd issue of an 8-row burst, then a fresh burst
    tick(); set_req(0, 10'h020, 8'd8, 2'b01); decide();
    tick(); decide();
    tick(); do_reset();
    tick(); decide();
    tick(); set_req(1, 10'h040, 8'd3, 2'b01); decide(); run(12);
    // dir 11, idle dir 00
    tick(); set_req(0, 10'h0AA, 8'd2, 2'b11); decide(); run(8);
    tick(); set_req(2, 10'h3FF, 8'd2, 2'b00); decide(); run(8);

    // random traffic
    while (cyc < NC - 100) begin
      tick();
      if (!sys_rst && $urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        for (int w = 0; w < 3; w++) begin
          if (!req_v[w] && $urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 3) == 0)
              ra[w] = AW'(1024 - $urandom_range(1, 8));
            else
              ra[w] = AW'($urandom_range(0, 1023));
            rl[w] = ($urandom_range(0, 5) == 0) ? '0 : CW'($urandom_range(1, 12));
            rd[w] = 2'($urandom_range(0, 3));
            req_v[w] = 1'b1;
          end
        end
        decide();
      end
    end
    req_v = '0;
    run(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
